div_sequencer: RTL and testbench

//  Request/response front-end for the 32/16 fixed iterative divider: accepts an operand pair
//  on a valid/ready handshake, pulses the divider init, holds operands stable while it iterates,

---
 rtl/div_seq_pkg.sv | 17 +
 rtl/div_sequencer_if.sv | 26 ++
 rtl/div_sign_fix.sv | 49 ++++
 rtl/div_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_div_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared constants and FSM state type for the divider request/response sequencer.
package div_seq_pkg;

    localparam int unsigned DVD_W       = 32;
    localparam int unsigned DVS_W       = 16;
    // Divider iterations after its init edge; one iteration per quotient bit.
    localparam int unsigned DIV_LATENCY = DVD_W;
    localparam int unsigned CNT_W       = $clog2(DIV_LATENCY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the ALU issue logic (master) and the sequencer (slave).
interface div_sequencer_if;
    import div_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [DVD_W-1:0] req_dividend;
    logic [DVS_W-1:0] req_divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DVD_W-1:0] rsp_quotient;
    logic [DVS_W-1:0] rsp_remainder;
    logic             rsp_div_zero;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero, rsp_ovf
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero, rsp_ovf
    );

endinterface

// File: rtl/div_sign_fix.sv
// Signed-division helpers: operand magnitudes and sign/overflow flags on entry,
// quotient/remainder sign restoration on capture. Purely combinational.
// Only instantiated when SIGNED_DIV_EN is defined.
module div_sign_fix
    import div_seq_pkg::*;
(
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVD_W-1:0] dvd_mag_o,
    output logic [DVS_W-1:0] dvs_mag_o,
    output logic             neg_quo_o,
    output logic             neg_rem_o,
    output logic             ovf_o,
    input  logic [DVD_W-1:0] quotient_i,
    input  logic [DVS_W-1:0] remainder_i,
    input  logic             neg_quo_i,
    input  logic             neg_rem_i,
    input  logic             ovf_i,
    output logic [DVD_W-1:0] quotient_o,
    output logic [DVS_W-1:0] remainder_o
);

    localparam logic [DVD_W-1:0] DvdMin = {1'b1, {(DVD_W-1){1'b0}}};

    logic dvd_neg;
    logic dvs_neg;

    // Entry: magnitudes for the unsigned divider, truncating-division sign rules.
    always_comb begin
        dvd_neg   = dividend_i[DVD_W-1];
        dvs_neg   = divisor_i[DVS_W-1];
        dvd_mag_o = dvd_neg ? -dividend_i : dividend_i;
        dvs_mag_o = dvs_neg ? -divisor_i : divisor_i;
        neg_quo_o = dvd_neg ^ dvs_neg;
        neg_rem_o = dvd_neg;
        ovf_o     = (dividend_i == DvdMin) && (divisor_i == '1);
    end

    // Capture: reapply signs; the MIN / -1 case is pinned to MIN rem 0.
    always_comb begin
        quotient_o  = neg_quo_i ? -quotient_i : quotient_i;
        remainder_o = neg_rem_i ? -remainder_i : remainder_i;
        if (ovf_i) begin
            quotient_o  = DvdMin;
            remainder_o = '0;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Front-end sequencer for the 32/16 iterative divider: handshakes a request, pulses the
// divider init, holds operands while it iterates, then presents the result until accepted.
// Divide-by-zero is answered directly without starting the divider.
// Optional feature: define SIGNED_DIV_EN for two's-complement operands (abs/negate/overflow).
module div_sequencer
    import div_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    div_sequencer_if.slave   bus,
    output logic             div_init,
    output logic [DVD_W-1:0] div_dividend,
    output logic [DVS_W-1:0] div_divisor,
    input  logic [DVD_W-1:0] div_quotient,
    input  logic [DVS_W-1:0] div_remainder
);

    localparam logic [CNT_W-1:0] LatCnt = CNT_W'(DIV_LATENCY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [DVD_W-1:0] entry_dvd;
    logic [DVS_W-1:0] entry_dvs;
    logic [DVD_W-1:0] fix_quo;
    logic [DVS_W-1:0] fix_rem;
    logic             fix_ovf;

    assign accept = (state_q == StIdle) && bus.req_valid;

`ifdef SIGNED_DIV_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic ovf_pend_q, ovf_pend_d;
    logic entry_neg_quo;
    logic entry_neg_rem;
    logic entry_ovf;

    div_sign_fix u_sign_fix (
        .dividend_i  (bus.req_dividend),
        .divisor_i   (bus.req_divisor),
        .dvd_mag_o   (entry_dvd),
        .dvs_mag_o   (entry_dvs),
        .neg_quo_o   (entry_neg_quo),
        .neg_rem_o   (entry_neg_rem),
        .ovf_o       (entry_ovf),
        .quotient_i  (div_quotient),
        .remainder_i (div_remainder),
        .neg_quo_i   (neg_quo_q),
        .neg_rem_i   (neg_rem_q),
        .ovf_i       (ovf_pend_q),
        .quotient_o  (fix_quo),
        .remainder_o (fix_rem)
    );

    assign fix_ovf = ovf_pend_q;

    // Sign flags are latched with the operands and consumed at capture.
    always_comb begin
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        ovf_pend_d = ovf_pend_q;
        if (accept) begin
            neg_quo_d  = entry_neg_quo;
            neg_rem_d  = entry_neg_rem;
            ovf_pend_d = entry_ovf;
        end
    end

    // Sign flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end
`else
    assign entry_dvd = bus.req_dividend;
    assign entry_dvs = bus.req_divisor;
    assign fix_quo   = div_quotient;
    assign fix_rem   = div_remainder;
    assign fix_ovf   = 1'b0;
`endif

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        dz_d          = dz_q;
        ovf_d         = ovf_q;
        div_init      = 1'b0;
        bus.req_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    dvd_d = entry_dvd;
                    dvs_d = entry_dvs;
                    if (bus.req_divisor == '0) begin
                        // Answered here; the divider is never started.
                        quo_d   = '1;
                        rem_d   = bus.req_dividend[DVS_W-1:0];
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                div_init = 1'b1;
                count_d  = '0;
                state_d  = StBusy;
            end
            StBusy: begin
                count_d = count_q + 1'b1;
                if (count_q == LatCnt) begin
                    quo_d   = fix_quo;
                    rem_d   = fix_rem;
                    dz_d    = 1'b0;
                    ovf_d   = fix_ovf;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter, operand and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.rsp_valid     = (state_q == StDone);
    assign bus.rsp_quotient  = quo_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_div_zero  = dz_q;
    assign bus.rsp_ovf       = ovf_q;
    assign div_dividend      = dvd_q;
    assign div_divisor       = dvs_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural 32-cycle divider model.
module tb_div_sequencer;
    import div_seq_pkg::*;

    logic             clock;
    logic             reset;
    logic             div_init;
    logic [DVD_W-1:0] div_dividend;
    logic [DVS_W-1:0] div_divisor;
    logic [DVD_W-1:0] div_quotient;
    logic [DVS_W-1:0] div_remainder;

    div_sequencer_if bus ();

    div_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .div_init      (div_init),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divider model: results valid only once 32 iterations after init have elapsed,
    // garbage before that; flags any operand pin change while iterating.
    int               m_cnt = 0;
    int               pin_err = 0;
    int               init_cnt = 0;
    logic [DVD_W-1:0] m_q = '0;
    logic [DVS_W-1:0] m_r = '0;
    logic [DVD_W-1:0] m_dvd = '0;
    logic [DVS_W-1:0] m_dvs = '0;

    always @(posedge clock) begin
        if (div_init) begin
            m_cnt <= DIV_LATENCY;
            m_dvd <= div_dividend;
            m_dvs <= div_divisor;
            m_q   <= (div_divisor != 0) ? div_dividend / {16'h0, div_divisor} : '1;
            m_r   <= (div_divisor != 0) ? DVS_W'(div_dividend % {16'h0, div_divisor}) : '0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (div_dividend != m_dvd || div_divisor != m_dvs) pin_err <= pin_err + 1;
        end
    end

    assign div_quotient  = (m_cnt == 0) ? m_q : 32'hDEAD_BEEF;
    assign div_remainder = (m_cnt == 0) ? m_r : 16'hBAD0;

    always @(negedge clock) if (div_init) init_cnt <= init_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
        int          lat;   // edges after the accept edge until rsp_valid; 0 = right after it
        int          hold;  // cycles of rsp_ready low after rsp_valid
    } vec_t;

    task automatic run_op(input int id, input vec_t v);
        int lat;
        int init0;
        int pin0;
        string n;
        n = $sformatf("vec%0d", id);
        @(negedge clock);
        check({n, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        init0 = init_cnt;
        pin0  = pin_err;
        bus.req_valid    = 1'b1;
        bus.req_dividend = v.dvd;
        bus.req_divisor  = v.dvs;
        @(posedge clock);
        #1;
        // Inputs changing after accept must be ignored.
        bus.req_valid    = 1'b0;
        bus.req_dividend = 32'hA5A5_5A5A;
        bus.req_divisor  = 16'h0;
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clock);
            lat++;
            #1;
        end
        check({n, "_latency"}, lat, v.lat);
        check({n, "_quotient"}, bus.rsp_quotient, v.q);
        check({n, "_remainder"}, {16'h0, bus.rsp_remainder}, {16'h0, v.r});
        check({n, "_div_zero"}, {31'b0, bus.rsp_div_zero}, {31'b0, v.dz});
        check({n, "_ovf"}, {31'b0, bus.rsp_ovf}, {31'b0, v.ovf});
        check({n, "_init_pulses"}, init_cnt - init0, v.dz ? 0 : 1);
        check({n, "_pin_stable"}, pin_err - pin0, 0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clock);
            check({n, "_hold_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
            check({n, "_hold_ready"}, {31'b0, bus.req_ready}, 32'd0);
            check({n, "_hold_q"}, bus.rsp_quotient, v.q);
            check({n, "_hold_r"}, {16'h0, bus.rsp_remainder}, {16'h0, v.r});
        end
        @(negedge clock);
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b0;
        check({n, "_done_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({n, "_done_ready"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b0;
        reset            = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_q", bus.rsp_quotient, 32'd0);
        check("rst_rsp_r", {16'h0, bus.rsp_remainder}, 32'd0);
        check("rst_div_init", {31'b0, div_init}, 32'd0);
        check("rst_div_dvd", div_dividend, 32'd0);
        check("rst_div_dvs", {16'h0, div_divisor}, 32'd0);

        vecs.push_back('{32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b0, 34, 10});
        vecs.push_back('{32'd1234, 16'd0, 32'hFFFF_FFFF, 16'd1234, 1'b1, 1'b0, 0, 0});
        vecs.push_back('{32'd7, 16'd9, 32'd0, 16'd7, 1'b0, 1'b0, 34, 0});
        vecs.push_back('{32'd0, 16'd3, 32'd0, 16'd0, 1'b0, 1'b0, 34, 0});
`ifdef SIGNED_DIV_EN
        vecs.push_back('{32'hFFFF_FFF9, 16'd2, 32'hFFFF_FFFD, 16'hFFFF, 1'b0, 1'b0, 34, 0});
        vecs.push_back('{32'd7, 16'hFFFE, 32'hFFFF_FFFD, 16'd1, 1'b0, 1'b0, 34, 0});
        vecs.push_back('{32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'd0, 1'b0, 1'b1, 34, 0});
        vecs.push_back('{32'hFFFF_FF9C, 16'd0, 32'hFFFF_FFFF, 16'hFF9C, 1'b1, 1'b0, 0, 0});
`else
        vecs.push_back('{32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 1'b0, 34, 0});
        vecs.push_back('{32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 1'b0, 34, 0});
        vecs.push_back('{32'hDEAD_BEEF, 16'h0010, 32'h0DEA_DBEE, 16'h000F, 1'b0, 1'b0, 34, 2});
`endif

        foreach (vecs[i]) run_op(i, vecs[i]);

        // Reset while BUSY with count==10: next edge returns to IDLE, result dropped.
        @(negedge clock);
        bus.req_valid    = 1'b1;
        bus.req_dividend = 32'd100;
        bus.req_divisor  = 16'd7;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        repeat (11) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        // Let the orphaned divider run out before the next operation.
        repeat (40) @(posedge clock);
        run_op(100, '{32'd50, 16'd5, 32'd10, 16'd0, 1'b0, 1'b0, 34, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
